// File: rtl/transmit_protocol.sv
// rtl/transmit_protocol.sv - single-wire S_Data frame serializer (preamble, packet, idle gap)
module transmit_protocol #(
    parameter int              PKT_W    = 55,
    parameter int              PRE_W    = 6,
    parameter logic [PRE_W-1:0] PREAMBLE = 6'b011111,
    parameter int              GAP      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PKT_W-1:0] packet_in,
    input  logic             send,
    output logic             tx_ready,
    output logic             S_Data,
    output logic             tx_done
);

    // Counter wide enough for the longest phase (the data phase counts PKT_W-1 down to 0).
    localparam int CW = $clog2(PKT_W + 1);
    // Power-of-two view of the bit sources so the counter indexes them without width games.
    localparam int EW = 1 << CW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CW-1:0]    bit_cnt;
    logic [CW-1:0]    cnt_n;
    logic [PKT_W-1:0] shift;
    logic [PKT_W-1:0] shift_n;
    logic             s_data_n;
    logic             ready_n;
    logic             done_n;
    logic             accept;
    logic [EW-1:0]    pre_ext;
    logic [EW-1:0]    shift_ext;

    assign accept    = send && tx_ready;
    assign pre_ext   = EW'(PREAMBLE);
    assign shift_ext = EW'(shift_n);

    // State, counter, packet latch and all outputs are registered; reset abandons any frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            shift    <= '0;
            S_Data   <= 1'b1;
            tx_ready <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= cnt_n;
            shift    <= shift_n;
            S_Data   <= s_data_n;
            tx_ready <= ready_n;
            tx_done  <= done_n;
        end
    end

    // Next-state sequencing; the line value is chosen from the state/count being entered so the
    // registered S_Data lines up with the bit the counter points at.
    always_comb begin
        state_n  = state;
        cnt_n    = bit_cnt;
        shift_n  = shift;
        done_n   = 1'b0;
        s_data_n = 1'b1;
        ready_n  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n = ST_PRE;
                    cnt_n   = CW'(PRE_W - 1);
                    shift_n = packet_in;
                end
            end
            ST_PRE: begin
                if (bit_cnt == '0) begin
                    state_n = ST_DATA;
                    cnt_n   = CW'(PKT_W - 1);
                end else begin
                    cnt_n = bit_cnt - CW'(1);
                end
            end
            ST_DATA: begin
                if (bit_cnt == '0) begin
                    state_n = ST_GAP;
                    cnt_n   = CW'(GAP - 1);
                    done_n  = 1'b1;
                end else begin
                    cnt_n = bit_cnt - CW'(1);
                end
            end
            ST_GAP: begin
                if (bit_cnt == '0) begin
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = bit_cnt - CW'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase

        case (state_n)
            ST_PRE:  s_data_n = pre_ext[cnt_n];
            ST_DATA: s_data_n = shift_ext[cnt_n];
            default: s_data_n = 1'b1;
        endcase

        ready_n = (state_n == ST_IDLE);
    end

endmodule

// File: tb/tb_transmit_protocol.sv
// tb/tb_transmit_protocol.sv - randomized scoreboard bench for transmit_protocol with loopback receiver
module tb_transmit_protocol;

    logic        clk;
    logic        rst;
    logic [54:0] packet_in;
    logic        send;
    logic        tx_ready;
    logic        S_Data;
    logic        tx_done;

    int checks;
    int passes;

    logic [2:0]  exp_q[$];
    logic [54:0] pkt_q[$];

    logic [5:0]  pre_v;
    int          cyc;
    int          e0;
    bit          active;
    bit          abort_rx;
    logic [54:0] cur;
    int          n_model;

    logic [5:0]  win;
    bit          rx_cap;
    int          rx_n;
    logic [54:0] rx_sh;
    int          n_rx;

    transmit_protocol dut (
        .clk       (clk),
        .rst       (rst),
        .packet_in (packet_in),
        .send      (send),
        .tx_ready  (tx_ready),
        .S_Data    (S_Data),
        .tx_done   (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        pre_v   = 6'b011111;
        cyc     = 0;
        e0      = 0;
        active  = 0;
        abort_rx = 0;
        cur     = '0;
        n_model = 0;
        win     = 6'h3f;
        rx_cap  = 0;
        rx_n    = 0;
        rx_sh   = '0;
        n_rx    = 0;
        checks  = 0;
        passes  = 0;
    end

    // Frame-level reference: each accepted packet occupies edges E0..E0+63, next accept at E0+64.
    always @(posedge clk) begin
        int          j;
        logic        s;
        logic        r;
        logic        d;
        logic [5:0]  t6;
        logic [54:0] t55;
        cyc = cyc + 1;
        if (rst) begin
            active   = 0;
            abort_rx = 1;
            exp_q.push_back(3'b110);
        end else begin
            abort_rx = 0;
            if (!active || (cyc - e0) >= 64) begin
                active = 0;
                if (send) begin
                    active = 1;
                    e0     = cyc;
                    cur    = packet_in;
                end
            end
            if (active) begin
                j = cyc - e0;
                if (j <= 5) begin
                    t6 = pre_v >> (5 - j);
                    s  = t6[0];
                end else if (j <= 60) begin
                    t55 = cur >> (60 - j);
                    s   = t55[0];
                end else begin
                    s = 1'b1;
                end
                d = (j == 61);
                r = (j >= 63);
                if (j == 60) begin
                    pkt_q.push_back(cur);
                    n_model = n_model + 1;
                end
                exp_q.push_back({s, r, d});
            end else begin
                exp_q.push_back(3'b110);
            end
        end
    end

    // Monitor: per-cycle line/handshake check plus a loopback receiver that reassembles frames.
    always @(negedge clk) begin
        logic [2:0]  e;
        logic [54:0] want;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks = checks + 1;
            if ({S_Data, tx_ready, tx_done} === e)
                passes = passes + 1;
            else
                $display("FAIL line cyc=%0d got s/r/d=%b%b%b want %b", cyc, S_Data, tx_ready, tx_done, e);

            if (abort_rx) begin
                rx_cap = 0;
                rx_n   = 0;
                win    = 6'h3f;
            end else if (rx_cap) begin
                rx_sh = {rx_sh[53:0], S_Data};
                rx_n  = rx_n + 1;
                if (rx_n == 55) begin
                    rx_cap = 0;
                    win    = 6'h3f;
                    n_rx   = n_rx + 1;
                    checks = checks + 1;
                    if (pkt_q.size() == 0) begin
                        $display("FAIL frame unexpected got %h want none", rx_sh);
                    end else begin
                        want = pkt_q.pop_front();
                        if (rx_sh === want)
                            passes = passes + 1;
                        else
                            $display("FAIL frame got %h want %h", rx_sh, want);
                    end
                end
            end else begin
                win = {win[4:0], S_Data};
                if (win == pre_v) begin
                    rx_cap = 1;
                    rx_n   = 0;
                end
            end
        end
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        rst       = 1'b1;
        send      = 1'b0;
        packet_in = '0;
        tick(2);
        rst = 1'b0;
        tick(10);

        // Single frame, alternating pattern.
        packet_in = 55'h55_AAAA_5555_AAAA;
        send = 1'b1;
        tick(1);
        send = 1'b0;
        packet_in = '0;
        tick(70);

        // Back-to-back frames with send held; packet changes right after the first accept.
        packet_in = 55'h1;
        send = 1'b1;
        tick(1);
        packet_in = 55'h7F_FFFF_FFFF_FFFF;
        tick(64);
        send = 1'b0;
        packet_in = '0;
        tick(70);

        // Sends during a frame are ignored.
        packet_in = 55'h12_3456_789A_BCDE;
        send = 1'b1;
        tick(1);
        send = 1'b0;
        tick(9);
        packet_in = 55'h7F_0000_FFFF_0000;
        send = 1'b1;
        tick(1);
        send = 1'b0;
        tick(29);
        send = 1'b1;
        tick(1);
        send = 1'b0;
        tick(40);

        // Reset mid-data abandons the frame; a fresh frame afterwards is complete.
        packet_in = 55'h2A_5A5A_0F0F_3C3C;
        send = 1'b1;
        tick(1);
        send = 1'b0;
        tick(29);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(3);
        packet_in = 55'h01_0203_0405_0607;
        send = 1'b1;
        tick(1);
        send = 1'b0;
        tick(70);

        // Send coincident with reset is not accepted.
        packet_in = 55'h3F_FFFF_0000_1111;
        send = 1'b1;
        rst  = 1'b1;
        tick(1);
        send = 1'b0;
        rst  = 1'b0;
        tick(5);

        // Loopback packet containing preamble-like runs.
        packet_in = 55'h0F_8000_0001_F03E;
        send = 1'b1;
        tick(1);
        send = 1'b0;
        tick(70);

        // Randomized traffic with packet_in churning every cycle and rare resets.
        for (int i = 0; i < 3000; i++) begin
            packet_in = 55'({$urandom(), $urandom()});
            send = ($urandom_range(0, 3) == 0);
            rst  = ($urandom_range(0, 299) == 0);
            tick(1);
        end
        rst  = 1'b0;
        send = 1'b0;
        tick(70);

        @(negedge clk);
        #1;
        checks = checks + 1;
        if (n_rx == n_model && n_model > 0)
            passes = passes + 1;
        else
            $display("FAIL frame_count got %0d want %0d", n_rx, n_model);
        checks = checks + 1;
        if (pkt_q.size() == 0)
            passes = passes + 1;
        else
            $display("FAIL pending_frames got %0d want 0", pkt_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
